// File: rtl/piton_core_wakeup_ctrl_if.sv
// Signal bundle between the tile reset/interrupt side and the core wake-up
// controller. The master side drives the wake/soft-reset requests and the raw
// interrupt lines. The slave side, which is the controller, returns the
// synchronised core reset and the gated interrupts.
// Optional: WAKEUP_BYPASS_EN adds wake_bypass_i, which skips the SRAM-init wait.
interface piton_core_wakeup_ctrl_if #(
    parameter int NrIrqLines = 2
);
`ifdef WAKEUP_BYPASS_EN
    logic                  wake_bypass_i;
`endif
    logic                  wake_req_i;
    logic                  soft_rst_req_i;
    logic [NrIrqLines-1:0] irq_i;
    logic                  ipi_i;
    logic                  time_irq_i;
    logic                  debug_req_i;
    logic                  spc_grst_l;
    logic [NrIrqLines-1:0] irq_o;
    logic                  ipi_o;
    logic                  time_irq_o;
    logic                  debug_req_o;
    logic [2:0]            state_o;

    modport master (
`ifdef WAKEUP_BYPASS_EN
        output wake_bypass_i,
`endif
        output wake_req_i,
        output soft_rst_req_i,
        output irq_i,
        output ipi_i,
        output time_irq_i,
        output debug_req_i,
        input  spc_grst_l,
        input  irq_o,
        input  ipi_o,
        input  time_irq_o,
        input  debug_req_o,
        input  state_o
    );

    modport slave (
`ifdef WAKEUP_BYPASS_EN
        input  wake_bypass_i,
`endif
        input  wake_req_i,
        input  soft_rst_req_i,
        input  irq_i,
        input  ipi_i,
        input  time_irq_i,
        input  debug_req_i,
        output spc_grst_l,
        output irq_o,
        output ipi_o,
        output time_irq_o,
        output debug_req_o,
        output state_o
    );
endinterface

// File: rtl/piton_core_wakeup_ctrl.sv
// Core wake-up, reset-release and interrupt-synchronisation controller.
// The controller holds the core in reset while the tile SRAMs initialise.
// It can optionally wait for an L15 wake-up pulse. It then releases a
// synchronised core reset (spc_grst_l), supports soft-reset re-entry from RUN,
// and synchronises the interrupt lines and gates them with the core reset.
// Optional: define WAKEUP_BYPASS_EN to add wake_bypass_i. This input treats the
// SRAM-init counter as expired while it is high.
module piton_core_wakeup_ctrl #(
    parameter int WakeCntWidth    = 16,
    parameter int WakeMode        = 0,
    parameter int SyncStages      = 2,
    parameter int NrIrqLines      = 2,
    parameter int ResetHoldCycles = 16
) (
    input logic                     clk_i,
    input logic                     reset_l,
    piton_core_wakeup_ctrl_if.slave bus
);

    localparam logic [2:0] WAIT_SRAM = 3'd0;
    localparam logic [2:0] WAIT_WAKE = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] SOFT_RST  = 3'd3;

    localparam int                     IrqW    = NrIrqLines + 3;
    localparam logic [WakeCntWidth-1:0] CntOne  = WakeCntWidth'(1);
    localparam logic [WakeCntWidth-1:0] HoldCnt = WakeCntWidth'(ResetHoldCycles);

    logic [2:0]              state_q, state_d;
    logic [WakeCntWidth-1:0] cnt_q, cnt_d;
    logic                    wake_q;
    logic                    wake_seen;
    logic                    cnt_expired;
    logic                    sram_done;
    logic                    rst_gate;
    logic [SyncStages-1:0]   grst_sync_q;
    logic [IrqW-1:0]         irq_sync_q [SyncStages];
    logic [IrqW-1:0]         irq_gated;

`ifdef WAKEUP_BYPASS_EN
    assign cnt_expired = cnt_q[WakeCntWidth-1] | bus.wake_bypass_i;
`else
    assign cnt_expired = cnt_q[WakeCntWidth-1];
`endif

    // In wake-pulse-only mode the SRAM wait is skipped entirely.
    assign sram_done = (WakeMode == 1) ? 1'b1 : cnt_expired;
    // A pulse arriving in the same cycle as the decision counts immediately.
    assign wake_seen = wake_q | bus.wake_req_i;
    assign rst_gate  = (state_q == RUN);

    // Next-state and counter update for the wake-up sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_SRAM: begin
                if (!cnt_q[WakeCntWidth-1]) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (sram_done) begin
                    if ((WakeMode == 0) || wake_seen) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAIT_WAKE;
                    end
                end
            end
            WAIT_WAKE: begin
                if (wake_seen) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.soft_rst_req_i) begin
                    state_d = SOFT_RST;
                    cnt_d   = '0;
                end
            end
            SOFT_RST: begin
                if (cnt_q == HoldCnt) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = WAIT_SRAM;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= WAIT_SRAM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky wake flag: only the states before the first RUN can record a pulse.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            wake_q <= 1'b0;
        end else if (bus.wake_req_i && ((state_q == WAIT_SRAM) || (state_q == WAIT_WAKE))) begin
            wake_q <= 1'b1;
        end
    end

    // Core reset release passes through a synchroniser chain.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            grst_sync_q <= '0;
        end else begin
            grst_sync_q <= {grst_sync_q[SyncStages-2:0], rst_gate};
        end
    end

    // Interrupt synchronisers. All lines share one chain of equal depth.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < SyncStages; i++) begin
                irq_sync_q[i] <= '0;
            end
        end else begin
            irq_sync_q[0] <= {bus.debug_req_i, bus.time_irq_i, bus.ipi_i, bus.irq_i};
            for (int i = 1; i < SyncStages; i++) begin
                irq_sync_q[i] <= irq_sync_q[i-1];
            end
        end
    end

    // Interrupts are held off while the core is in reset.
    assign irq_gated = irq_sync_q[SyncStages-1] & {IrqW{grst_sync_q[SyncStages-1]}};

    assign bus.spc_grst_l  = grst_sync_q[SyncStages-1];
    assign bus.irq_o       = irq_gated[NrIrqLines-1:0];
    assign bus.ipi_o       = irq_gated[NrIrqLines];
    assign bus.time_irq_o  = irq_gated[NrIrqLines+1];
    assign bus.debug_req_o = irq_gated[NrIrqLines+2];
    assign bus.state_o     = state_q;

endmodule
